mix_columns: RTL and testbench

// AES MixColumns (or InvMixColumns) stage feeding add_round_key. Latches a 128-bit

---
 rtl/mix_columns.sv | 181 ++++++++++++++++++
 tb/tb_mix_columns.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mix_columns.sv
// AES MixColumns / InvMixColumns stage.
// Latches a 128-bit state on start, transforms one 32-bit column per cycle
// over GF(2^8) mod 0x11B, then presents the whole block with a one-cycle
// valid_out pulse. valid_out can drive a downstream add_round_key start.
module mix_columns #(
    parameter bit INVERSE = 1'b0
) (
    input  logic         clk_in,
    input  logic         rst_in,
    input  logic         start,
    input  logic         bypass,
    input  logic [127:0] block_in,
    output logic [127:0] result_out,
    output logic         valid_out,
    output logic         busy
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COMPUTE = 2'd1,
        OUTPUT  = 2'd2
    } state_t;

    state_t       state_r;
    logic [1:0]   col_idx_r;
    logic [127:0] block_r;
    logic [127:0] result_r;
    logic         bypass_r;
    logic [31:0]  col_in_s;
    logic [31:0]  col_out_s;

    // Multiply by x (02) in GF(2^8) with the AES reduction polynomial.
    function automatic logic [7:0] xtime(input logic [7:0] b);
        xtime = {b[6:0], 1'b0} ^ (b[7] ? 8'h1B : 8'h00);
    endfunction

    function automatic logic [7:0] mul3(input logic [7:0] b);
        mul3 = xtime(b) ^ b;
    endfunction

    // 09/0b/0d/0e are sums of b, 2b, 4b and 8b built from chained xtime.
    function automatic logic [7:0] mul9(input logic [7:0] b);
        logic [7:0] x2, x4, x8;
        x2   = xtime(b);
        x4   = xtime(x2);
        x8   = xtime(x4);
        mul9 = x8 ^ b;
    endfunction

    function automatic logic [7:0] mulb(input logic [7:0] b);
        logic [7:0] x2, x4, x8;
        x2   = xtime(b);
        x4   = xtime(x2);
        x8   = xtime(x4);
        mulb = x8 ^ x2 ^ b;
    endfunction

    function automatic logic [7:0] muld(input logic [7:0] b);
        logic [7:0] x2, x4, x8;
        x2   = xtime(b);
        x4   = xtime(x2);
        x8   = xtime(x4);
        muld = x8 ^ x4 ^ b;
    endfunction

    function automatic logic [7:0] mule(input logic [7:0] b);
        logic [7:0] x2, x4, x8;
        x2   = xtime(b);
        x4   = xtime(x2);
        x8   = xtime(x4);
        mule = x8 ^ x4 ^ x2;
    endfunction

    // Forward column transform, matrix rows rotate {02,03,01,01}.
    function automatic logic [31:0] mix_fwd(input logic [31:0] col);
        logic [7:0] a0, a1, a2, a3;
        a0 = col[31:24];
        a1 = col[23:16];
        a2 = col[15:8];
        a3 = col[7:0];
        mix_fwd = {xtime(a0) ^ mul3(a1) ^ a2 ^ a3,
                   a0 ^ xtime(a1) ^ mul3(a2) ^ a3,
                   a0 ^ a1 ^ xtime(a2) ^ mul3(a3),
                   mul3(a0) ^ a1 ^ a2 ^ xtime(a3)};
    endfunction

    // Inverse column transform, matrix rows rotate {0e,0b,0d,09}.
    function automatic logic [31:0] mix_inv(input logic [31:0] col);
        logic [7:0] a0, a1, a2, a3;
        a0 = col[31:24];
        a1 = col[23:16];
        a2 = col[15:8];
        a3 = col[7:0];
        mix_inv = {mule(a0) ^ mulb(a1) ^ muld(a2) ^ mul9(a3),
                   mul9(a0) ^ mule(a1) ^ mulb(a2) ^ muld(a3),
                   muld(a0) ^ mul9(a1) ^ mule(a2) ^ mulb(a3),
                   mulb(a0) ^ muld(a1) ^ mul9(a2) ^ mule(a3)};
    endfunction

    // Select the latched column addressed by col_idx (column 0 at the MSBs).
    always_comb begin
        col_in_s = 32'h0000_0000;
        case (col_idx_r)
            2'd0:    col_in_s = block_r[127:96];
            2'd1:    col_in_s = block_r[95:64];
            2'd2:    col_in_s = block_r[63:32];
            2'd3:    col_in_s = block_r[31:0];
            default: col_in_s = 32'h0000_0000;
        endcase
    end

    // Column datapath: pass-through in bypass, otherwise forward or inverse mix.
    always_comb begin
        col_out_s = col_in_s;
        if (bypass_r) begin
            col_out_s = col_in_s;
        end else if (INVERSE) begin
            col_out_s = mix_inv(col_in_s);
        end else begin
            col_out_s = mix_fwd(col_in_s);
        end
    end

    // Control FSM with registered outputs: accept, four column cycles, publish.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_r    <= IDLE;
            col_idx_r  <= 2'd0;
            block_r    <= 128'd0;
            result_r   <= 128'd0;
            bypass_r   <= 1'b0;
            result_out <= 128'd0;
            valid_out  <= 1'b0;
            busy       <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    valid_out <= 1'b0;
                    if (start) begin
                        block_r   <= block_in;
                        bypass_r  <= bypass;
                        col_idx_r <= 2'd0;
                        busy      <= 1'b1;
                        state_r   <= COMPUTE;
                    end else begin
                        busy      <= 1'b0;
                    end
                end
                COMPUTE: begin
                    case (col_idx_r)
                        2'd0:    result_r[127:96] <= col_out_s;
                        2'd1:    result_r[95:64]  <= col_out_s;
                        2'd2:    result_r[63:32]  <= col_out_s;
                        2'd3:    result_r[31:0]   <= col_out_s;
                        default: result_r         <= result_r;
                    endcase
                    // The 3->0 wrap lands exactly on the move to OUTPUT.
                    col_idx_r <= col_idx_r + 2'd1;
                    if (col_idx_r == 2'd3) begin
                        state_r <= OUTPUT;
                    end else begin
                        state_r <= COMPUTE;
                    end
                end
                OUTPUT: begin
                    result_out <= result_r;
                    valid_out  <= 1'b1;
                    busy       <= 1'b0;
                    state_r    <= IDLE;
                end
                default: begin
                    state_r   <= IDLE;
                    col_idx_r <= 2'd0;
                    valid_out <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mix_columns.sv
// Self-checking bench for mix_columns: a forward and an inverse instance,
// optionally chained, with scoreboard queues popped on each valid_out pulse.
module tb_mix_columns;

    logic         clk_in = 1'b0;
    logic         rst_in = 1'b1;

    logic         f_start = 1'b0;
    logic         f_bypass = 1'b0;
    logic [127:0] f_block = 128'd0;
    logic [127:0] f_result;
    logic         f_valid;
    logic         f_busy;

    logic         chain_mode = 1'b0;
    logic         i_start_tb = 1'b0;
    logic [127:0] i_block_tb = 128'd0;
    logic         i_start;
    logic [127:0] i_block;
    logic [127:0] i_result;
    logic         i_valid;
    logic         i_busy;

    int n_cmp  = 0;
    int n_fail = 0;
    int lat;
    logic [127:0] fq[$];
    logic [127:0] iq[$];
    logic [127:0] blk;
    logic [127:0] exp_v;

    assign i_start = chain_mode ? f_valid  : i_start_tb;
    assign i_block = chain_mode ? f_result : i_block_tb;

    always #5 clk_in = ~clk_in;

    mix_columns #(.INVERSE(1'b0)) u_fwd (
        .clk_in(clk_in), .rst_in(rst_in), .start(f_start), .bypass(f_bypass),
        .block_in(f_block), .result_out(f_result), .valid_out(f_valid), .busy(f_busy)
    );

    mix_columns #(.INVERSE(1'b1)) u_inv (
        .clk_in(clk_in), .rst_in(rst_in), .start(i_start), .bypass(1'b0),
        .block_in(i_block), .result_out(i_result), .valid_out(i_valid), .busy(i_busy)
    );

    // Generic shift-and-add GF(2^8) multiply mod 0x11B.
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] aa = a;
        logic [7:0] bb = b;
        for (int k = 0; k < 8; k++) begin
            if (bb[0]) p = p ^ aa;
            aa = aa[7] ? ((aa << 1) ^ 8'h1B) : (aa << 1);
            bb = bb >> 1;
        end
        return p;
    endfunction

    // Reference block transform as a circulant matrix product per column.
    function automatic logic [127:0] model_mix(input logic [127:0] b, input bit inv);
        logic [7:0] coef [4];
        logic [127:0] r = 128'd0;
        logic [7:0] acc;
        if (inv) begin
            coef[0] = 8'h0e; coef[1] = 8'h0b; coef[2] = 8'h0d; coef[3] = 8'h09;
        end else begin
            coef[0] = 8'h02; coef[1] = 8'h03; coef[2] = 8'h01; coef[3] = 8'h01;
        end
        for (int c = 0; c < 4; c++) begin
            for (int i = 0; i < 4; i++) begin
                acc = 8'h00;
                for (int j = 0; j < 4; j++)
                    acc = acc ^ gf_mul(coef[(j - i + 4) % 4], b[127 - 8 * (4 * c + j) -: 8]);
                r[127 - 8 * (4 * c + i) -: 8] = acc;
            end
        end
        return r;
    endfunction

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    // Scoreboard: every valid pulse must match the oldest pending expectation.
    always @(negedge clk_in) begin
        if (f_valid === 1'b1) begin
            if (fq.size() == 0) check("fwd_unexpected_valid", {127'd0, f_valid}, 128'd0);
            else check("fwd_result", f_result, fq.pop_front());
        end
        if (i_valid === 1'b1) begin
            if (iq.size() == 0) check("inv_unexpected_valid", {127'd0, i_valid}, 128'd0);
            else check("inv_result", i_result, iq.pop_front());
        end
    end

    // Called #1 after an edge: start is sampled at the next edge (edge k).
    task automatic fwd_send(input logic [127:0] b, input logic byp, input logic [127:0] e);
        f_block  = b;
        f_bypass = byp;
        f_start  = 1'b1;
        fq.push_back(e);
        @(posedge clk_in); #1;
        f_start  = 1'b0;
    endtask

    // Counts edges after edge k until valid_out is seen (bounded).
    task automatic wait_valid(input bit use_inv, input int first, output int l);
        l = 99;
        for (int i = first; i <= 12; i++) begin
            @(posedge clk_in); #1;
            if ((use_inv ? i_valid : f_valid) === 1'b1) begin
                l = i;
                break;
            end
        end
    endtask

    initial begin
        // Reset state
        #12;
        check("rst_result", f_result, 128'd0);
        check("rst_valid", {127'd0, f_valid}, 128'd0);
        check("rst_busy", {127'd0, f_busy}, 128'd0);
        check("rst_inv_result", i_result, 128'd0);
        rst_in = 1'b0;
        @(posedge clk_in); #1;

        // FIPS vector 1
        fwd_send(128'hdb135345_f20a225c_01010101_c6c6c6c6, 1'b0,
                 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6);
        check("busy_compute", {127'd0, f_busy}, 128'd1);
        wait_valid(1'b0, 1, lat);
        check("latency_fips1", lat, 5);
        @(posedge clk_in); #1;
        check("valid_one_cycle", {127'd0, f_valid}, 128'd0);
        check("busy_idle", {127'd0, f_busy}, 128'd0);
        check("result_held", f_result, 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6);

        // FIPS vector 2
        fwd_send(128'hd4d4d4d5_2d26314c_01010101_c6c6c6c6, 1'b0,
                 128'hd5d5d7d6_4d7ebdf8_01010101_c6c6c6c6);
        wait_valid(1'b0, 1, lat);
        check("latency_fips2", lat, 5);
        @(posedge clk_in); #1;

        // Inverse standalone on FIPS output
        i_block_tb = 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6;
        i_start_tb = 1'b1;
        iq.push_back(128'hdb135345_f20a225c_01010101_c6c6c6c6);
        @(posedge clk_in); #1;
        i_start_tb = 1'b0;
        wait_valid(1'b1, 1, lat);
        check("latency_inv", lat, 5);
        @(posedge clk_in); #1;

        // Bypass then normal block
        blk = 128'h00112233_44556677_8899aabb_ccddeeff;
        fwd_send(blk, 1'b1, blk);
        wait_valid(1'b0, 1, lat);
        check("latency_bypass", lat, 5);
        @(posedge clk_in); #1;
        fwd_send(blk, 1'b0, model_mix(blk, 1'b0));
        wait_valid(1'b0, 1, lat);
        check("latency_after_bypass", lat, 5);
        @(posedge clk_in); #1;

        // start while busy ignored; back-to-back start at k+6 accepted
        blk = 128'h0f1e2d3c_4b5a6978_8796a5b4_c3d2e1f0;
        fwd_send(blk, 1'b0, model_mix(blk, 1'b0));
        @(posedge clk_in); #1;
        f_block = 128'hffeeddcc_bbaa9988_77665544_33221100;
        f_start = 1'b1;
        @(posedge clk_in); #1;
        f_start = 1'b0;
        wait_valid(1'b0, 3, lat);
        check("latency_ignore_busy", lat, 5);
        blk = 128'h13579bdf_2468ace0_fdb97531_0eca8642;
        fwd_send(blk, 1'b0, model_mix(blk, 1'b0));
        wait_valid(1'b0, 1, lat);
        check("latency_back_to_back", lat, 5);
        @(posedge clk_in); #1;

        // Async reset mid-COMPUTE aborts the block
        blk = 128'hcafebabe_deadbeef_01234567_89abcdef;
        fwd_send(blk, 1'b0, model_mix(blk, 1'b0));
        @(posedge clk_in);
        #3 rst_in = 1'b1;
        #1;
        check("abort_result", f_result, 128'd0);
        check("abort_valid", {127'd0, f_valid}, 128'd0);
        check("abort_busy", {127'd0, f_busy}, 128'd0);
        void'(fq.pop_back());
        #2 rst_in = 1'b0;
        wait_valid(1'b0, 1, lat);
        check("abort_no_pulse", lat, 99);
        blk = 128'h11223344_55667788_99aabbcc_ddeeff00;
        fwd_send(blk, 1'b0, model_mix(blk, 1'b0));
        wait_valid(1'b0, 1, lat);
        check("latency_after_reset", lat, 5);
        @(posedge clk_in); #1;

        // block_in changes after accept are ignored
        blk = 128'h3243f6a8_885a308d_313198a2_e0370734;
        fwd_send(blk, 1'b0, model_mix(blk, 1'b0));
        lat = 99;
        for (int i = 1; i <= 12; i++) begin
            f_block = {$urandom, $urandom, $urandom, $urandom};
            @(posedge clk_in); #1;
            if (f_valid === 1'b1) begin
                lat = i;
                break;
            end
        end
        check("latency_input_churn", lat, 5);
        @(posedge clk_in); #1;

        // Forward -> inverse chained round trip
        chain_mode = 1'b1;
        for (int n = 0; n < 100; n++) begin
            blk = {$urandom, $urandom, $urandom, $urandom};
            iq.push_back(blk);
            fwd_send(blk, 1'b0, model_mix(blk, 1'b0));
            wait_valid(1'b0, 1, lat);
            check("latency_chain", lat, 5);
            @(posedge clk_in); #1;
        end
        repeat (10) @(posedge clk_in);
        #1;
        chain_mode = 1'b0;

        check("fwd_queue_drained", fq.size(), 128'd0);
        check("inv_queue_drained", iq.size(), 128'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
